mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port unified memory between the fetch stage (IF) and the memory stage (DM).
//   Grants one access at a time and sequences the memory's fixed read/write latency.
//   Returns one response pulse per access.
//   Drives per-port stall outputs that freeze the pipeline registers while a stage waits.
// PARAMETERS
//   AW          32  address width
//   DW          32  data width
//   MEM_LAT     1   memory access cycles (>=1)
//   STARVE_MAX  4   consecutive DM grants while IF waits before IF is forced (>=1)
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high
//   if_req     in   1   fetch request; hold with if_addr until if_gnt
//   if_addr    in   AW  fetch address
//   if_gnt     out  1   fetch request accepted this cycle
//   if_rvalid  out  1   one-cycle pulse: if_rdata valid
//   if_rdata   out  DW  fetched word
//   if_stall   out  1   if_req & ~if_rvalid
//   dm_req     in   1   data request; hold with dm_we/addr/wdata until dm_gnt
//   dm_we      in   1   1 = write, 0 = read
//   dm_addr    in   AW  data address
//   dm_wdata   in   DW  write data
//   dm_gnt     out  1   data request accepted this cycle
//   dm_rvalid  out  1   one-cycle pulse: read data valid or write done
//   dm_rdata   out  DW  read data (holds last read value on write ack)
//   dm_stall   out  1   dm_req & ~dm_rvalid
//   mem_en     out  1   memory access active
//   mem_we     out  1   memory write enable
//   mem_addr   out  AW  memory address
//   mem_wdata  out  DW  memory write data
//   mem_rdata  in   DW  memory read data, valid in the last BUSY cycle
// BEHAVIOUR
//   - Reset: FSM=IDLE; starve count, cnt, gnt, rvalid, mem_en, mem_we = 0; rdata, mem_addr, mem_wdata = 0.
//   - FSM states IDLE, BUSY_IF, BUSY_DM.
//   - IDLE: if_gnt/dm_gnt are combinational and one-hot.
//     - DM wins by default.
//     - IF wins if only if_req is high, or if starve count == STARVE_MAX.
//   - Grant edge: latch we/addr/wdata into mem_*; mem_en=1; cnt=MEM_LAT-1; go to BUSY_x.
//   - BUSY_x: mem_* held stable; cnt decrements each cycle; no grants.
//   - At the edge where cnt==0: capture mem_rdata into x_rdata (reads only); x_rvalid=1 next cycle; mem_en=mem_we=0; go to IDLE.
//   - Latency: grant in cycle T; rvalid in cycle T+MEM_LAT+1.
//   - A new grant can occur in the rvalid cycle, so throughput is one access per MEM_LAT+1 cycles.
//   - Starve count:
//     - +1 on each DM grant while if_req=1, saturating at STARVE_MAX.
//     - Cleared on an IF grant or when if_req=0.
//   - Dropping a request before its grant has no side effect. A request changed after its grant is ignored until IDLE.
//   - Simultaneous if_req/dm_req in IDLE: exactly one grant; the loser waits with its stall held.
//   - Reset mid-BUSY: access aborted, no rvalid, mem_we cleared immediately (asynchronously).
// CONFIGURATION
//   PERF_CNT_EN defined:
//     - Adds out ports perf_if_wait[31:0] and perf_dm_wait[31:0].
//     - Each counts cycles with x_req=1 and x_gnt=0; saturates at all-ones; cleared by reset.
//   PERF_CNT_EN undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//   mem_arb_pkg: arb_state_t enum {IDLE, BUSY_IF, BUSY_DM}; port_id_t enum {PORT_IF, PORT_DM}.
//   Sub-module mem_arb_starve_ctr: saturating starve counter with force_if output.
//   FSM, latency counter and response registers live in the top level.
// TESTING
//   1. Reset, then single IF read at 0x10, MEM_LAT=1: if_gnt@T, mem_en@T+1, if_rvalid and word@T+2.
//   2. if_req and dm_req (read 0x20) together:
//      - dm_gnt first; if_stall=1 throughout.
//      - IF granted in the DM rvalid cycle.
//   3. DM write 0xDEADBEEF to 0x40, then DM read 0x40: mem_we high only in the write BUSY cycle; the read returns 0xDEADBEEF.
//   4. dm_req held continuously with if_req high, STARVE_MAX=4: after 4 DM grants the next grant goes to IF; the count returns to 0.
//   5. Assert reset during BUSY_DM write (MEM_LAT=3):
//      - mem_en/mem_we drop immediately; no dm_rvalid.
//      - After reset, FSM=IDLE.
//   6. PERF_CNT_EN: hold if_req for 3 waiting cycles behind a DM access: perf_if_wait==3 and perf_dm_wait==0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY_IF, BUSY_DM)
//   port_id_t   : requesting port identifier (PORT_IF, PORT_DM)
//   busy_state(): maps a winning port to the BUSY state that serves it
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_id_t;

  function automatic arb_state_t busy_state(input port_id_t p);
    return (p == PORT_IF) ? BUSY_IF : BUSY_DM;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: counts consecutive DM grants taken while IF is waiting.
// Once the count reaches STARVE_MAX, force_if tells the arbiter to hand the
// next grant to IF.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   if_req     : IF request (count clears whenever IF is not requesting)
//   if_gnt     : IF granted this cycle (clears the count)
//   dm_gnt     : DM granted this cycle (increments while IF waits)
//   force_if   : count has saturated at STARVE_MAX
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output logic force_if
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!if_req || if_gnt) begin
      count <= '0;
    end else if (dm_gnt && (count != SW'(STARVE_MAX))) begin
      count <= count + 1'b1;
    end
  end

  assign force_if = (count == SW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch (IF) and
// memory (DM) pipeline stages, one access at a time, with a fixed MEM_LAT
// access latency.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   if_req/if_addr          : fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata/if_stall : fetch grant, response pulse, data, stall
//   dm_req/dm_we/dm_addr/dm_wdata      : data request, held until dm_gnt
//   dm_gnt/dm_rvalid/dm_rdata/dm_stall : data grant, response pulse, data, stall
//   mem_en/mem_we/mem_addr/mem_wdata   : registered memory command
//   mem_rdata               : memory read data, valid in the last BUSY cycle
//   dbg_state               : current arbiter FSM state
//   perf_if_wait/perf_dm_wait : saturating wait-cycle counters, present only
//                               when PERF_CNT_EN is defined
// Handshake: a port raises x_req with its command and holds them stable until
// x_gnt is seen high in the same cycle; the access is then owned by the
// arbiter and exactly one x_rvalid pulse follows MEM_LAT+1 cycles later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output arb_state_t    dbg_state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]   perf_if_wait,
  output logic [31:0]   perf_dm_wait
`endif
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic          idle;
  logic          force_if;
  port_id_t      win;

  // Grants are only offered in IDLE and never while reset is applied.
  // DM wins ties unless IF has been starved for STARVE_MAX grants.
  assign idle   = (state == IDLE) && !reset;
  assign if_gnt = idle && if_req && (!dm_req || force_if);
  assign dm_gnt = idle && dm_req && !if_gnt;
  assign win    = if_gnt ? PORT_IF : PORT_DM;

  assign if_stall  = if_req && !if_rvalid;
  assign dm_stall  = dm_req && !dm_rvalid;
  assign dbg_state = state;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .dm_gnt  (dm_gnt),
    .force_if(force_if)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt || dm_gnt) begin
            mem_en <= 1'b1;
            cnt    <= CW'(MEM_LAT - 1);
            state  <= busy_state(win);
            if (if_gnt) begin
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end else begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (cnt == '0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= IDLE;
            if (state == BUSY_IF) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end else begin
              dm_rvalid <= 1'b1;
              // A write ack leaves the last read value in place.
              if (!mem_we) dm_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_if_wait <= '0;
      perf_dm_wait <= '0;
    end else begin
      if (if_req && !if_gnt && (perf_if_wait != '1)) perf_if_wait <= perf_if_wait + 1'b1;
      if (dm_req && !dm_gnt && (perf_dm_wait != '1)) perf_dm_wait <= perf_dm_wait + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// u_dut  runs MEM_LAT=1 against a small memory model, driven from a
//        cycle-by-cycle vector table, with a read-data scoreboard.
// u_dut3 runs MEM_LAT=3 for the reset-during-BUSY sequence and, when
//        PERF_CNT_EN is defined, the wait-counter sequence.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic rst3;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT (MEM_LAT=1) ----------------
  logic          if_req, if_gnt, if_rvalid, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid, dm_stall;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  arb_state_t    state1;
`ifdef PERF_CNT_EN
  logic [31:0]   perf_if1, perf_dm1;
`endif

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(state1)
`ifdef PERF_CNT_EN
    , .perf_if_wait(perf_if1), .perf_dm_wait(perf_dm1)
`endif
  );

  // ---------------- DUT (MEM_LAT=3) ----------------
  logic          d3_if_req, d3_if_gnt, d3_if_rvalid, d3_if_stall;
  logic [AW-1:0] d3_if_addr;
  logic [DW-1:0] d3_if_rdata;
  logic          d3_dm_req, d3_dm_we, d3_dm_gnt, d3_dm_rvalid, d3_dm_stall;
  logic [AW-1:0] d3_dm_addr;
  logic [DW-1:0] d3_dm_wdata, d3_dm_rdata;
  logic          d3_mem_en, d3_mem_we;
  logic [AW-1:0] d3_mem_addr;
  logic [DW-1:0] d3_mem_wdata;
  logic [DW-1:0] d3_mem_rdata;
  arb_state_t    state3;
`ifdef PERF_CNT_EN
  logic [31:0]   perf_if3, perf_dm3;
`endif

  assign d3_mem_rdata = 32'h0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(rst3),
    .if_req(d3_if_req), .if_addr(d3_if_addr), .if_gnt(d3_if_gnt), .if_rvalid(d3_if_rvalid),
    .if_rdata(d3_if_rdata), .if_stall(d3_if_stall),
    .dm_req(d3_dm_req), .dm_we(d3_dm_we), .dm_addr(d3_dm_addr), .dm_wdata(d3_dm_wdata),
    .dm_gnt(d3_dm_gnt), .dm_rvalid(d3_dm_rvalid), .dm_rdata(d3_dm_rdata), .dm_stall(d3_dm_stall),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
    .mem_rdata(d3_mem_rdata), .dbg_state(state3)
`ifdef PERF_CNT_EN
    , .perf_if_wait(perf_if3), .perf_dm_wait(perf_dm3)
`endif
  );

  // ---------------- memory model (u_dut) ----------------
  logic [DW-1:0] mem_arr [0:63];
  logic [DW-1:0] ref_mem [0:63];

  function automatic logic [DW-1:0] init_word(input int idx);
    return 32'hA5A5_0000 ^ (idx * 4);
  endfunction

  assign mem_rdata = mem_en ? mem_arr[mem_addr[7:2]] : '0;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard (u_dut read data) ----------------
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] dm_exp_q[$];
  logic [DW-1:0] last_dm_rd;
  logic          sb_en = 1'b0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (if_rvalid) begin
        checks++;
        if (if_exp_q.size() == 0) begin
          failures++;
          $display("FAIL if_rdata_unexpected actual=%0h expected=none", if_rdata);
        end else begin
          logic [DW-1:0] e;
          e = if_exp_q.pop_front();
          if (if_rdata !== e) begin
            failures++;
            $display("FAIL if_rdata actual=%0h expected=%0h", if_rdata, e);
          end
        end
      end
      if (dm_rvalid) begin
        checks++;
        if (dm_exp_q.size() == 0) begin
          failures++;
          $display("FAIL dm_rdata_unexpected actual=%0h expected=none", dm_rdata);
        end else begin
          logic [DW-1:0] e;
          e = dm_exp_q.pop_front();
          if (dm_rdata !== e) begin
            failures++;
            $display("FAIL dm_rdata actual=%0h expected=%0h", dm_rdata, e);
          end
        end
      end
      if (if_gnt) if_exp_q.push_back(ref_mem[if_addr[7:2]]);
      if (dm_gnt) begin
        if (dm_we) begin
          ref_mem[dm_addr[7:2]] = dm_wdata;
          dm_exp_q.push_back(last_dm_rd);
        end else begin
          last_dm_rd = ref_mem[dm_addr[7:2]];
          dm_exp_q.push_back(last_dm_rd);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  // exp bits: {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid, if_stall, dm_stall}
  typedef struct packed {
    logic        if_req;
    logic [7:0]  if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [7:0]  exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                     input logic [7:0] da, input logic [31:0] wd, input logic [7:0] e);
    vec_t v;
    v = '{if_req: ir, if_addr: ia, dm_req: dr, dm_we: dw, dm_addr: da, dm_wdata: wd, exp: e};
    vq.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input vec_t v);
    if_req   = v.if_req;
    if_addr  = {24'h0, v.if_addr};
    dm_req   = v.dm_req;
    dm_we    = v.dm_we;
    dm_addr  = {24'h0, v.dm_addr};
    dm_wdata = v.dm_wdata;
  endtask

  task automatic d3_idle();
    d3_if_req = 1'b0; d3_if_addr = '0;
    d3_dm_req = 1'b0; d3_dm_we = 1'b0; d3_dm_addr = '0; d3_dm_wdata = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t zero_v;
    bit   rv_seen;
    bit   got;
    zero_v = '0;
    last_dm_rd = '0;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    drive_vec(zero_v);
    d3_idle();
    reset = 1'b1;
    rst3  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid}, 6'b0);
    check("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
    check("rst_mem", {mem_addr, mem_wdata}, 64'h0);
    check("rst_state", 64'(state1), 64'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    rst3  = 1'b0;
    sb_en = 1'b1;

    // single IF read, then IF/DM collision, write/read-back, starvation
    add(1, 8'h10, 0, 0, 8'h00, 32'h0,         8'b1000_0010);
    add(1, 8'h10, 0, 0, 8'h00, 32'h0,         8'b0010_0010);
    add(0, 8'h00, 0, 0, 8'h00, 32'h0,         8'b0000_1000);
    add(1, 8'h14, 1, 0, 8'h20, 32'h0,         8'b0100_0011);
    add(1, 8'h14, 1, 0, 8'h20, 32'h0,         8'b0010_0011);
    add(1, 8'h14, 0, 0, 8'h00, 32'h0,         8'b1000_0110);
    add(1, 8'h14, 0, 0, 8'h00, 32'h0,         8'b0010_0010);
    add(0, 8'h00, 0, 0, 8'h00, 32'h0,         8'b0000_1000);
    add(0, 8'h00, 1, 1, 8'h40, 32'hDEADBEEF,  8'b0100_0001);
    add(0, 8'h00, 1, 1, 8'h40, 32'hDEADBEEF,  8'b0011_0001);
    add(0, 8'h00, 1, 0, 8'h40, 32'h0,         8'b0100_0100);
    add(0, 8'h00, 1, 0, 8'h40, 32'h0,         8'b0010_0001);
    add(0, 8'h00, 0, 0, 8'h00, 32'h0,         8'b0000_0100);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0100_0011);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0010_0011);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0100_0110);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0010_0011);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0100_0110);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0010_0011);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0100_0110);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0010_0011);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b1000_0110);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0010_0011);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0100_1001);
    add(1, 8'h18, 1, 0, 8'h24, 32'h0,         8'b0010_0011);
    add(0, 8'h00, 0, 0, 8'h00, 32'h0,         8'b0000_0100);
    add(0, 8'h00, 0, 0, 8'h00, 32'h0,         8'b0000_0000);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive_vec(vq[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid, if_stall, dm_stall},
            vq[i].exp);
    end
    @(posedge clk); #1;
    drive_vec(zero_v);
    @(negedge clk);
    check("if_q_drained", 64'(if_exp_q.size()), 64'd0);
    check("dm_q_drained", 64'(dm_exp_q.size()), 64'd0);

    // reset during a MEM_LAT=3 DM write
    @(posedge clk); #1;
    d3_dm_req = 1'b1; d3_dm_we = 1'b1; d3_dm_addr = 32'h40; d3_dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("l3_dm_gnt", d3_dm_gnt, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("l3_busy_cmd", {d3_mem_en, d3_mem_we}, 2'b11);
    check("l3_busy_state", 64'(state3), 64'(BUSY_DM));
    #2;
    rst3 = 1'b1;
    #1;
    check("l3_rst_cmd", {d3_mem_en, d3_mem_we}, 2'b00);
    d3_idle();
    @(posedge clk); #1;
    rst3 = 1'b0;
    rv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d3_dm_rvalid) rv_seen = 1'b1;
    end
    check("l3_no_rvalid", rv_seen, 1'b0);
    check("l3_state_idle", 64'(state3), 64'(IDLE));

`ifdef PERF_CNT_EN
    // IF waits 3 cycles behind one MEM_LAT=3 DM read
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(posedge clk); #1;
    d3_dm_req = 1'b1; d3_dm_we = 1'b0; d3_dm_addr = 32'h8;
    @(negedge clk);
    check("perf_dm_gnt", d3_dm_gnt, 1'b1);
    @(posedge clk); #1;
    d3_dm_req = 1'b0;
    d3_if_req = 1'b1; d3_if_addr = 32'h10;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (d3_if_gnt) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("perf_if_gnt_seen", got, 1'b1);
    @(posedge clk); #1;
    d3_if_req = 1'b0;
    @(negedge clk);
    check("perf_if_wait", perf_if3, 32'd3);
    check("perf_dm_wait", perf_dm3, 32'd0);
`else
    got = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
